// File: rtl/irq_service_responder.sv
// rtl/irq_service_responder.sv - CPU-side request/ack responder for the 27-channel interrupt controller
// Optional ack timeout enabled by defining IRQ_SERVICE_TIMEOUT_EN.
module irq_service_responder #(
    parameter int HOLD_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pa,
    input  logic        pb,
    input  logic        pc,
    input  logic [3:0]  chan,
    input  logic        cpu_ack,
    input  logic        err_clr,
    output logic        irq_req,
    output logic [5:0]  irq_vec,
    output logic [26:0] clr_onehot,
    output logic        busy,
    output logic        err_chan,
    output logic        timeout_flag,
    output logic [7:0]  service_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_CLR  = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
        $error("HOLD_CYCLES out of range 1..255");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range 1..255");
    end

    state_t      state_q;
    logic        irq_req_q;
    logic [5:0]  irq_vec_q;
    logic [26:0] clr_q;
    logic        busy_q;
    logic        err_chan_q;
    logic [7:0]  svc_cnt_q;
    logic [7:0]  hold_cnt_q;

    logic        any_bus;
    logic        chan_ok;
    logic [1:0]  win_bus;
    logic [4:0]  clr_idx;
    logic [26:0] clr_mask;
    logic [7:0]  svc_cnt_inc;
    logic        err_set;
    logic        tmo_expire;

    always_comb begin
        any_bus     = pa | pb | pc;
        chan_ok     = (chan <= 4'd8);
        win_bus     = pa ? 2'd0 : (pb ? 2'd1 : 2'd2);
        // Clear index comes from the latched vector, never from live inputs.
        clr_idx     = 5'(irq_vec_q[5:4]) * 5'd9 + {1'b0, irq_vec_q[3:0]};
        clr_mask    = 27'd1 << clr_idx;
        svc_cnt_inc = (svc_cnt_q == 8'hff) ? svc_cnt_q : svc_cnt_q + 8'd1;
        err_set     = (state_q == S_IDLE) && any_bus && !chan_ok;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            irq_req_q  <= 1'b0;
            irq_vec_q  <= '0;
            clr_q      <= '0;
            busy_q     <= 1'b0;
            err_chan_q <= 1'b0;
            svc_cnt_q  <= '0;
            hold_cnt_q <= '0;
        end else begin
            clr_q      <= '0;
            err_chan_q <= err_set | (err_chan_q & ~err_clr);
            case (state_q)
                S_IDLE: begin
                    if (any_bus && chan_ok) begin
                        state_q   <= S_REQ;
                        irq_req_q <= 1'b1;
                        irq_vec_q <= {win_bus, chan};
                        busy_q    <= 1'b1;
                    end
                end
                S_REQ: begin
                    // Ack wins over a timeout expiring on the same edge.
                    if (cpu_ack) begin
                        state_q   <= S_CLR;
                        irq_req_q <= 1'b0;
                        clr_q     <= clr_mask;
                        svc_cnt_q <= svc_cnt_inc;
                    end else if (tmo_expire) begin
                        state_q    <= S_HOLD;
                        irq_req_q  <= 1'b0;
                        hold_cnt_q <= HOLD_LOAD;
                    end
                end
                S_CLR: begin
                    state_q    <= S_HOLD;
                    hold_cnt_q <= HOLD_LOAD;
                end
                S_HOLD: begin
                    if (hold_cnt_q == 8'd0) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    irq_req_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

`ifdef IRQ_SERVICE_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] tmo_cnt_q;
    logic       timeout_flag_q;

    assign tmo_expire = (state_q == S_REQ) && (tmo_cnt_q == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q      <= '0;
            timeout_flag_q <= 1'b0;
        end else begin
            if (state_q != S_REQ) begin
                tmo_cnt_q <= '0;
            end else if (!cpu_ack) begin
                tmo_cnt_q <= tmo_cnt_q + 8'd1;
            end
            timeout_flag_q <= (tmo_expire & ~cpu_ack) | (timeout_flag_q & ~err_clr);
        end
    end

    assign timeout_flag = timeout_flag_q;
`else
    assign tmo_expire   = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    assign irq_req     = irq_req_q;
    assign irq_vec     = irq_vec_q;
    assign clr_onehot  = clr_q;
    assign busy        = busy_q;
    assign err_chan    = err_chan_q;
    assign service_cnt = svc_cnt_q;

endmodule

// File: tb/tb_irq_service_responder.sv
// tb/tb_irq_service_responder.sv - randomized transaction-level bench for irq_service_responder
module tb_irq_service_responder;

    localparam int HOLD = 4;
    localparam int TMO  = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pa, pb, pc;
    logic [3:0]  chan;
    logic        cpu_ack;
    logic        err_clr;
    logic        irq_req;
    logic [5:0]  irq_vec;
    logic [26:0] clr_onehot;
    logic        busy;
    logic        err_chan;
    logic        timeout_flag;
    logic [7:0]  service_cnt;

    int total = 0;
    int bad   = 0;
    int n_svc = 0;

    irq_service_responder #(
        .HOLD_CYCLES   (HOLD),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pa          (pa),
        .pb          (pb),
        .pc          (pc),
        .chan        (chan),
        .cpu_ack     (cpu_ack),
        .err_clr     (err_clr),
        .irq_req     (irq_req),
        .irq_vec     (irq_vec),
        .clr_onehot  (clr_onehot),
        .busy        (busy),
        .err_chan    (err_chan),
        .timeout_flag(timeout_flag),
        .service_cnt (service_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_cnt();
        return (n_svc > 255) ? 255 : n_svc;
    endfunction

    // Wait out HOLD, returning cycles until busy drops and whether any clear appeared.
    task automatic wait_idle(output int k, output bit saw_clr);
        k = 0;
        saw_clr = 0;
        while (busy === 1'b1 && k < 300) begin
            if (clr_onehot !== '0) saw_clr = 1;
            step();
            k++;
        end
    endtask

    task automatic service(input logic [2:0] buses, input logic [3:0] ch, input int ack_dly,
                           input logic [2:0] b_after, input logic [3:0] ch_after);
        int          w;
        logic [5:0]  vec;
        logic [26:0] onehot;
        int          k;
        bit          saw;
        w      = buses[0] ? 0 : (buses[1] ? 1 : 2);
        vec    = {2'(w), ch};
        onehot = 27'd1 << (w * 9 + int'(ch));
        {pc, pb, pa} = buses;
        chan = ch;
        step();
        chk("req_up", {31'd0, irq_req}, 1);
        chk("vec", {26'd0, irq_vec}, {26'd0, vec});
        chk("busy_req", {31'd0, busy}, 1);
        {pc, pb, pa} = b_after;
        chan = ch_after;
        for (int i = 0; i < ack_dly; i++) begin
            step();
            chk("req_hold", {25'd0, irq_req, irq_vec}, {25'd0, 1'b1, vec});
        end
        cpu_ack = 1'b1;
        step();
        cpu_ack = 1'b0;
        n_svc++;
        chk("clr_pulse", {5'd0, clr_onehot}, {5'd0, onehot});
        chk("req_drop", {31'd0, irq_req}, 0);
        chk("svc_cnt", {24'd0, service_cnt}, exp_cnt());
        step();
        chk("clr_once", {5'd0, clr_onehot}, 0);
        chk("vec_keep", {26'd0, irq_vec}, {26'd0, vec});
        wait_idle(k, saw);
        chk("hold_len", k, HOLD);
        chk("hold_noclr", {31'd0, saw}, 0);
    endtask

    initial begin
        int  k;
        bit  saw;
        int  nclr;
        logic [2:0] rb;
        logic [3:0] rc;
        rst_n = 1'b0; pa = 0; pb = 0; pc = 0; chan = 0; cpu_ack = 0; err_clr = 0;
        step();
        step();
        chk("rst_req", {31'd0, irq_req}, 0);
        chk("rst_vec", {26'd0, irq_vec}, 0);
        chk("rst_clr", {5'd0, clr_onehot}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_err", {30'd0, err_chan, timeout_flag}, 0);
        chk("rst_cnt", {24'd0, service_cnt}, 0);
        rst_n = 1'b1;
        step();

        service(3'b010, 4'd5, 2, 3'b000, 4'd0);
        chk("t1_cnt", {24'd0, service_cnt}, 1);

        service(3'b101, 4'd8, 1, 3'b100, 4'd3);
        service(3'b100, 4'd3, 0, 3'b000, 4'd0);

        pa = 1; chan = 4'd11;
        step();
        chk("err_set", {31'd0, err_chan}, 1);
        chk("err_noreq", {30'd0, irq_req, busy}, 0);
        pa = 0; err_clr = 1;
        step();
        chk("err_clr", {31'd0, err_chan}, 0);
        pa = 1; chan = 4'd14;
        step();
        chk("err_same", {31'd0, err_chan}, 1);
        pa = 0;
        step();
        err_clr = 0;
        chk("err_clr2", {31'd0, err_chan}, 0);

        pa = 1; chan = 4'd1;
        step();
        chk("rq_req", {31'd0, irq_req}, 1);
        rst_n = 0;
        #1;
        chk("rq_rst", {24'd0, irq_req, busy, irq_vec}, 0);
        chk("rq_rstcnt", {24'd0, service_cnt}, 0);
        n_svc = 0;
        pa = 0;
        step();
        rst_n = 1;
        nclr = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (clr_onehot !== '0 || busy !== 1'b0) nclr++;
        end
        chk("rq_quiet", nclr, 0);

        pb = 1; chan = 4'd2;
        step();
        cpu_ack = 1;
        pb = 0;
        step();
        cpu_ack = 0;
        chk("clr_seen", {5'd0, clr_onehot}, {5'd0, 27'd1 << 11});
        rst_n = 0;
        #1;
        chk("clr_rst", {5'd0, clr_onehot}, 0);
        chk("clr_rstcnt", {23'd0, busy, service_cnt}, 0);
        step();
        rst_n = 1;
        nclr = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (clr_onehot !== '0) nclr++;
        end
        chk("clr_quiet", nclr, 0);

        for (int i = 0; i < 40; i++) begin
            rb = 3'($urandom_range(0, 7));
            rc = 4'($urandom_range(0, 12));
            if (rb == 3'b000) begin
                {pc, pb, pa} = 3'b000;
                chan = rc;
                step();
                step();
                chk("rnd_idle", {30'd0, busy, irq_req}, 0);
            end else if (rc > 4'd8) begin
                {pc, pb, pa} = rb;
                chan = rc;
                step();
                chk("rnd_err", {29'd0, err_chan, irq_req, busy}, {29'd0, 3'b100});
                {pc, pb, pa} = 3'b000;
                err_clr = 1;
                step();
                err_clr = 0;
                chk("rnd_errclr", {31'd0, err_chan}, 0);
            end else begin
                service(rb, rc, $urandom_range(0, 5), 3'($urandom_range(0, 7)),
                        4'($urandom_range(0, 15)));
            end
        end

        rst_n = 0;
        step();
        rst_n = 1;
        n_svc = 0;
        {pc, pb, pa} = 3'b000;
        for (int i = 0; i < 256; i++) begin
            service(3'b001, 4'(i % 9), 0, 3'b000, 4'd0);
        end
        chk("sat", {24'd0, service_cnt}, 255);

`ifdef IRQ_SERVICE_TIMEOUT_EN
        pa = 1; chan = 4'd4;
        step();
        pa = 0;
        nclr = 0;
        for (int i = 0; i < TMO - 1; i++) begin
            step();
            if (irq_req !== 1'b1) nclr++;
        end
        chk("tmo_reqheld", nclr, 0);
        step();
        chk("tmo_drop", {31'd0, irq_req}, 0);
        chk("tmo_flag", {31'd0, timeout_flag}, 1);
        chk("tmo_noclr", {5'd0, clr_onehot}, 0);
        chk("tmo_cnt", {24'd0, service_cnt}, 255);
        wait_idle(k, saw);
        chk("tmo_hold", k, HOLD);
        chk("tmo_holdclr", {31'd0, saw}, 0);
        err_clr = 1;
        step();
        err_clr = 0;
        chk("tmo_clr", {31'd0, timeout_flag}, 0);
        service(3'b010, 4'd7, TMO - 1, 3'b000, 4'd0);
        chk("tmo_ackwin", {31'd0, timeout_flag}, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
